packet_deframer: RTL and testbench
==================================

PACKET_DEFRAMER -- requirements
Module: packet_deframer

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-002 SHALL have parameter TIMEOUT, default 255, max idle cycles between bytes inside a frame (1..65535).
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_byte  input  8  received byte.
REQ-006 SHALL have port in_valid  input  1  in_byte valid this cycle; no backpressure.
REQ-007 SHALL have port word  output  32  assembled payload, first payload byte in [31:24].
REQ-008 SHALL have port word_valid  output  1  one-cycle pulse, word and crc_ok valid.
REQ-009 SHALL have port crc_ok  output  1  received CRC byte matches computed CRC.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on inter-byte timeout abort.
REQ-011 SHALL have port busy  output  1  high in any state other than HUNT.

Function
REQ-012 SHALL implement FSM states HUNT, PAYLOAD, CHECK.
REQ-013 SHALL stay in HUNT and discard bytes until in_valid with in_byte==SYNC_BYTE, then go to PAYLOAD with byte index 0.
REQ-014 SHALL in PAYLOAD shift each valid byte into a 32-bit register MSB-first, going to CHECK after the 4th byte.
REQ-015 SHALL in CHECK treat the next valid byte as CRC, return to HUNT, and on the following cycle pulse word_valid (1-cycle latency from CRC byte).
REQ-016 SHALL compute CRC-8/DVB-S2: poly 0xD5, init 0x00, no reflection, no final XOR, over the 4 payload bytes in arrival order.
REQ-017 SHALL hold word and crc_ok stable from the word_valid pulse until the next word_valid pulse or reset.
REQ-018 SHALL treat a SYNC_BYTE value received inside PAYLOAD or CHECK as data, never as a restart.
REQ-019 SHALL count idle cycles in PAYLOAD/CHECK, clear the count on every valid byte, and on reaching TIMEOUT pulse frame_err, return to HUNT, and leave word unchanged.
REQ-020 SHALL give a valid byte priority over a timeout expiring in the same cycle.
REQ-021 SHALL accept a SYNC_BYTE in HUNT in the same cycle word_valid or frame_err pulses, so back-to-back frames need no gap cycle.
REQ-022 SHALL keep word_valid and frame_err mutually exclusive.

Reset
REQ-023 SHALL on rst force state HUNT, word=0, word_valid=0, crc_ok=0, frame_err=0, busy=0, byte index and timeout count=0.
REQ-024 SHALL on rst mid-frame discard the partial frame with no word_valid or frame_err pulse.

Configuration
REQ-025 SHALL support macro PACKET_DEFRAMER_CRC_CHECK_EN.
REQ-026 SHALL with PACKET_DEFRAMER_CRC_CHECK_EN defined compute CRC and drive crc_ok per REQ-016.
REQ-027 SHALL with PACKET_DEFRAMER_CRC_CHECK_EN undefined still consume the CRC byte and frame timing unchanged, but include no CRC logic and drive crc_ok=1 with every word_valid.

Verification
REQ-028 SHALL test: bytes A5,00,00,00,01,D5 -> word_valid one cycle after D5, word=32'h00000001, crc_ok=1.
REQ-029 SHALL test: bytes A5,00,00,00,01,D4 -> word=32'h00000001, crc_ok=0 (1 with macro undefined).
REQ-030 SHALL test: bytes 12,34,A5,01,00,00,00,45 -> leading bytes ignored, word=32'h01000000, crc_ok=1.
REQ-031 SHALL test: A5,11,22 then no valid for TIMEOUT cycles -> frame_err pulse once, busy=0, word unchanged, word_valid never set.
REQ-032 SHALL test: two back-to-back frames, second A5 on the cycle of the first word_valid -> two word_valid pulses, both correct.
REQ-033 SHALL test: rst asserted after A5,11 -> all outputs at reset values next cycle; a following full valid frame decodes correctly.

Source files
------------

// File: rtl/packet_deframer.sv
// packet_deframer: hunts for SYNC_BYTE, assembles a 4-byte payload MSB-first,
// then consumes one CRC-8/DVB-S2 byte and reports the word with a one-cycle
// word_valid pulse. Long idle gaps inside a frame abort it with frame_err.
//
// Optional feature macro: PACKET_DEFRAMER_CRC_CHECK_EN
//   defined   -> CRC is computed over the payload and compared to the CRC byte
//   undefined -> no CRC logic; the CRC byte is still consumed, crc_ok reads 1
module packet_deframer #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        crc_ok,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    CHECK
  } state_t;

  // Idle counter value at which the next idle cycle aborts the frame.
  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [1:0]  byte_idx;
  logic [15:0] idle_cnt;
  logic [31:0] shift_reg;

`ifdef PACKET_DEFRAMER_CRC_CHECK_EN
  logic [7:0] crc;

  // One byte of CRC-8 poly 0xD5, MSB first, no reflection.
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'hD5) : (r << 1);
    end
    return r;
  endfunction
`endif

  // The frame is in progress whenever we are not hunting for a sync byte.
  assign busy = (state != HUNT);

  // Frame FSM: sync hunt, payload assembly, CRC byte, idle timeout, pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HUNT;
      byte_idx   <= 2'd0;
      idle_cnt   <= 16'd0;
      shift_reg  <= 32'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
      crc_ok     <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PACKET_DEFRAMER_CRC_CHECK_EN
      crc        <= 8'h00;
`endif
    end else begin
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        HUNT: begin
          idle_cnt <= 16'd0;
          byte_idx <= 2'd0;
          if (in_valid && (in_byte == SYNC_BYTE)) begin
            state <= PAYLOAD;
`ifdef PACKET_DEFRAMER_CRC_CHECK_EN
            crc   <= 8'h00;
`endif
          end
        end

        PAYLOAD: begin
          if (in_valid) begin
            idle_cnt  <= 16'd0;
            shift_reg <= {shift_reg[23:0], in_byte};
            byte_idx  <= byte_idx + 2'd1;
`ifdef PACKET_DEFRAMER_CRC_CHECK_EN
            crc       <= crc8_step(crc, in_byte);
`endif
            if (byte_idx == 2'd3) begin
              state <= CHECK;
            end
          end else if (idle_cnt == IDLE_LAST) begin
            frame_err <= 1'b1;
            state     <= HUNT;
            idle_cnt  <= 16'd0;
            byte_idx  <= 2'd0;
          end else begin
            idle_cnt <= idle_cnt + 16'd1;
          end
        end

        CHECK: begin
          if (in_valid) begin
            idle_cnt   <= 16'd0;
            word       <= shift_reg;
            word_valid <= 1'b1;
`ifdef PACKET_DEFRAMER_CRC_CHECK_EN
            crc_ok     <= (in_byte == crc);
`else
            crc_ok     <= 1'b1;
`endif
            state      <= HUNT;
          end else if (idle_cnt == IDLE_LAST) begin
            frame_err <= 1'b1;
            state     <= HUNT;
            idle_cnt  <= 16'd0;
            byte_idx  <= 2'd0;
          end else begin
            idle_cnt <= idle_cnt + 16'd1;
          end
        end

        default: begin
          state <= HUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packet_deframer.sv
// tb_packet_deframer: directed frames for packet_deframer. Each call to
// applyStimulus is one clock cycle: outputs from the previous edge are checked
// against a scoreboard of expected words, then new inputs are driven.
module tb_packet_deframer;

  localparam int unsigned TIMEOUT = 255;
  localparam logic [7:0]  SYNC    = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic [31:0] word;
  logic        word_valid;
  logic        crc_ok;
  logic        frame_err;
  logic        busy;

  typedef struct {
    logic [31:0] w;
    logic        ok;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          vectors      = 0;
  int          miscompares  = 0;
  int          cyc          = 0;
  int          exp_ferr_due = -1;
  logic [31:0] held_word    = 32'd0;
  logic        held_crc     = 1'b0;
  logic        pend_busy    = 1'b0;
  bit          checking     = 1'b0;

  packet_deframer #(
    .SYNC_BYTE (SYNC),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .word       (word),
    .word_valid (word_valid),
    .crc_ok     (crc_ok),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Bit-serial CRC-8/DVB-S2 reference over the payload, first byte first.
  function automatic logic [7:0] crc8_ref(input logic [31:0] w);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 31; i >= 0; i--) begin
      fb = c[7] ^ w[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ 8'hD5;
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, want, cyc);
    end
  endtask

  task automatic checkOutput();
    check("frame_err", {31'd0, frame_err}, {31'd0, (cyc == exp_ferr_due)});
    check("busy", {31'd0, busy}, {31'd0, pend_busy});
    check("word_valid/frame_err exclusive", {31'd0, word_valid & frame_err}, 32'd0);
    if (word_valid) begin
      if (sb.size() == 0) begin
        check("spurious word_valid", {31'd0, word_valid}, 32'd0);
      end else begin
        check("word_valid cycle", 32'(cyc), 32'(sb[0].due));
        held_word = sb[0].w;
        held_crc  = sb[0].ok;
        sb.delete(0);
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      check("missing word_valid", {31'd0, word_valid}, 32'd1);
      sb.delete(0);
    end
    check("word", word, held_word);
    check("crc_ok", {31'd0, crc_ok}, {31'd0, held_crc});
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] b, input logic eb);
    @(negedge clk);
    cyc++;
    if (checking) checkOutput();
    rst       = r;
    in_valid  = v;
    in_byte   = b;
    pend_busy = eb;
    if (r) begin
      held_word    = 32'd0;
      held_crc     = 1'b0;
      exp_ferr_due = -1;
      sb.delete();
      checking     = 1'b1;
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input logic eb);
    applyStimulus(1'b0, 1'b1, b, eb);
  endtask

  // Idle cycles drive the sync value on in_byte to show in_valid gates it.
  task automatic idle(input logic eb);
    applyStimulus(1'b0, 1'b0, SYNC, eb);
  endtask

  task automatic sendFrame(input logic [31:0] w, input logic [7:0] crcb, input int gap);
    logic ok;
    sendByte(SYNC, 1'b1);
    for (int i = 0; i < 4; i++) begin
      repeat (gap) idle(1'b1);
      sendByte(w[31-8*i -: 8], 1'b1);
    end
    repeat (gap) idle(1'b1);
    sendByte(crcb, 1'b0);
`ifdef PACKET_DEFRAMER_CRC_CHECK_EN
    ok = (crcb == crc8_ref(w));
`else
    ok = 1'b1;
`endif
    sb.push_back('{w, ok, cyc + 1});
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    idle(1'b0);
    idle(1'b0);

    $display("[TB] good CRC frame");
    sendFrame(32'h00000001, 8'hD5, 0);
    idle(1'b0);

    $display("[TB] bad CRC frame");
    sendFrame(32'h00000001, 8'hD4, 0);
    idle(1'b0);

    $display("[TB] leading garbage before sync");
    sendByte(8'h12, 1'b0);
    sendByte(8'h34, 1'b0);
    sendFrame(32'h01000000, 8'h45, 0);
    idle(1'b0);
    idle(1'b0);

    $display("[TB] inter-byte timeout");
    sendByte(SYNC, 1'b1);
    sendByte(8'h11, 1'b1);
    sendByte(8'h22, 1'b1);
    for (int i = 1; i <= int'(TIMEOUT); i++) idle(i < int'(TIMEOUT));
    exp_ferr_due = cyc + 1;
    idle(1'b0);
    idle(1'b0);

    $display("[TB] back-to-back frames, sync inside payload");
    sendFrame(32'hDEADBEEF, crc8_ref(32'hDEADBEEF), 0);
    sendFrame(32'hA5A5A5A5, crc8_ref(32'hA5A5A5A5), 0);
    sendFrame(32'h00A50000, 8'h00, 0);
    idle(1'b0);

    $display("[TB] valid byte on the last idle cycle before timeout");
    sendFrame(32'hCAFEF00D, crc8_ref(32'hCAFEF00D), int'(TIMEOUT) - 1);
    idle(1'b0);

    $display("[TB] reset mid-frame");
    sendByte(SYNC, 1'b1);
    sendByte(8'h11, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    idle(1'b0);
    sendFrame(32'h12345678, crc8_ref(32'h12345678), 0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);

    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
